mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/cpu_pkg.sv | 11 +
 rtl/mem_access_if.sv | 11 +
 rtl/mem_timer.sv | 20 ++
 rtl/mem_access.sv | 122 ++++++++++++
 tb/tb_mem_access.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes and the memory-access FSM encoding.
package cpu_pkg;
  localparam logic [3:0] OP_STA = 4'b0110;
  localparam logic [3:0] OP_LDA = 4'b0111;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_STA) || (op == OP_LDA);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// Memory bus control/address group; the shared data bus stays a plain inout.
interface mem_access_if;
  logic [15:0] addr;
  logic        nMREQ;
  logic        nDRD;
  logic        nDWR;
  logic        nWAIT;

  modport master (output addr, nMREQ, nDRD, nDWR, input nWAIT);
  modport slave  (input addr, nMREQ, nDRD, nDWR, output nWAIT);
endinterface

// File: rtl/mem_timer.sv
// Loadable down-counter with zero flag; counts down freely until it reaches zero.
module mem_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_access.sv
// Execute-phase memory access sequencer: SETUP -> STROBE (+waits) -> HOLD with
// registered, glitch-free strobes and a wait-timeout abort.
module mem_access
  import cpu_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int WAIT_MAX   = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         t3,
  input  logic [15:0]  ir,
  input  logic [15:0]  aluout,
  input  logic [7:0]   wdata,
  mem_access_if.master bus,
  inout  wire  [7:0]   data,
  output logic [7:0]   mdr,
  output logic         wbin,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_t     state, state_n;
  logic       start, tload, capture, abort, tzero;
  logic       is_lda, lda_n, wait_ph, oe;
  logic [3:0] tval;
  logic [7:0] wdata_q;
  logic       unused_ir;

  assign unused_ir = ^ir[11:0];

  mem_timer #(.W(4)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Once the minimum width expires, every nWAIT-low edge is an extension;
  // the timer is reloaded to bound how many extensions are allowed.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    tload   = 1'b0;
    tval    = '0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state)
      ST_IDLE: if (t3 && is_mem_op(ir[15:12])) begin
        start   = 1'b1;
        tload   = 1'b1;
        tval    = 4'(SETUP_CYC - 1);
        state_n = ST_SETUP;
      end
      ST_SETUP: if (tzero) begin
        tload   = 1'b1;
        tval    = 4'(STROBE_CYC - 1);
        state_n = ST_STROBE;
      end
      ST_STROBE: if (tzero || wait_ph) begin
        if (bus.nWAIT) begin
          capture = is_lda;
          state_n = ST_HOLD;
        end else if (wait_ph && tzero) begin
          abort   = 1'b1;
          state_n = ST_HOLD;
        end else if (!wait_ph) begin
          tload   = 1'b1;
          tval    = 4'(WAIT_MAX - 1);
        end
      end
      ST_HOLD: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign lda_n = start ? (ir[15:12] == OP_LDA) : is_lda;

  // Bus controls are computed from the next state so they leave flops directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.addr  <= '0;
      bus.nMREQ <= 1'b1;
      bus.nDRD  <= 1'b1;
      bus.nDWR  <= 1'b1;
      oe        <= 1'b0;
      is_lda    <= 1'b0;
      wait_ph   <= 1'b0;
      wdata_q   <= '0;
      mdr       <= '0;
      wbin      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (start) begin
        bus.addr <= aluout;
        is_lda   <= lda_n;
        if (!lda_n) wdata_q <= wdata;
      end
      wait_ph   <= (state_n == ST_STROBE) && (wait_ph || (state == ST_STROBE && tzero));
      bus.nMREQ <= (state_n == ST_IDLE);
      bus.nDRD  <= !((state_n == ST_STROBE) && lda_n);
      bus.nDWR  <= !((state_n == ST_STROBE) && !lda_n);
      oe        <= (state_n != ST_IDLE) && !lda_n;
      if (capture) mdr <= data;
      wbin      <= capture;
      done      <= (state == ST_HOLD);
      if (start)      err <= 1'b0;
      else if (abort) err <= 1'b1;
    end
  end

  assign data = oe ? wdata_q : 8'hzz;
  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of accesses plus reset/ignore sequences.
module tb_mem_access;
  logic        clk;
  logic        rst;
  logic        t3;
  logic [15:0] ir;
  logic [15:0] aluout;
  logic [7:0]  wdata;
  logic [7:0]  mdr;
  logic        wbin, busy, done, err;
  logic [7:0]  rd_val;
  logic        probe;
  wire  [7:0]  data;
  int          checks = 0;
  int          errors = 0;

  mem_access_if mbus();

  mem_access dut (
    .clk    (clk),
    .rst    (rst),
    .t3     (t3),
    .ir     (ir),
    .aluout (aluout),
    .wdata  (wdata),
    .bus    (mbus),
    .data   (data),
    .mdr    (mdr),
    .wbin   (wbin),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Memory answers reads while nDRD is low; probe drives a marker to test for high-Z.
  assign data = !mbus.nDRD ? rd_val : 8'hzz;
  assign data = probe ? 8'h51 : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          lda;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          nw;
    bit          poke;
    bit          b2b;
    int          exp_w;
    int          exp_done;
    logic [7:0]  exp_mdr;
    int          exp_wb;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_hiz(input string name);
    probe = 1'b1;
    #1;
    chk(name, {24'h0, data}, 32'h51);
    probe = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit chain, input bit tail);
    int sw = 0, bad_sw = 0, wb = 0, mreq = 0, dok = 0, aok = 0, both = 0, done_c = -1;
    bit seen = 0;
    bit stb;
    if (!chain) @(negedge clk);
    t3     = 1'b1;
    ir     = v.lda ? 16'h7123 : 16'h6456;
    aluout = v.addr;
    wdata  = v.wd;
    rd_val = v.rd;
    @(posedge clk);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      t3 = 1'b0; ir = 16'h0000; aluout = 16'h0000; wdata = 8'h00;
      if (v.poke && c == 1) begin
        t3 = 1'b1; ir = 16'h6ABC; aluout = 16'hDEAD; wdata = 8'h11;
      end
      if (c == 0) chk($sformatf("v%0d busy", idx), {31'h0, busy}, 32'h1);
      if (!mbus.nDRD && !mbus.nDWR) both++;
      stb = v.lda ? !mbus.nDRD : !mbus.nDWR;
      if (stb) sw++;
      if (v.lda ? !mbus.nDWR : !mbus.nDRD) bad_sw++;
      if (!mbus.nMREQ) begin
        mreq++;
        if (mbus.addr == v.addr) aok++;
        if (!v.lda && data == v.wd) dok++;
      end
      if (wbin) wb++;
      if (done) begin seen = 1; done_c = c; end
      mbus.nWAIT = !(stb && sw >= 2 && sw < 2 + v.nw);
    end
    mbus.nWAIT = 1'b1;
    chk($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
    chk($sformatf("v%0d strobe_width", idx), sw, v.exp_w);
    chk($sformatf("v%0d wrong_strobe", idx), bad_sw, 0);
    chk($sformatf("v%0d both_low", idx), both, 0);
    chk($sformatf("v%0d mreq_cycles", idx), mreq, v.exp_done);
    chk($sformatf("v%0d addr_held", idx), aok, v.exp_done);
    if (!v.lda) chk($sformatf("v%0d sta_data", idx), dok, v.exp_done);
    chk($sformatf("v%0d wbin_pulses", idx), wb, v.exp_wb);
    chk($sformatf("v%0d mdr", idx), {24'h0, mdr}, {24'h0, v.exp_mdr});
    chk($sformatf("v%0d err", idx), {31'h0, err}, v.exp_err);
    if (tail) begin
      @(negedge clk);
      chk($sformatf("v%0d done_single", idx), {30'h0, done, busy}, 32'h0);
      check_hiz($sformatf("v%0d data_hiz", idx));
    end
  endtask

  initial begin
    int bad, seen_stb;
    //          lda addr      wd     rd     nw  poke b2b w   done mdr    wb err
    vecs[0] = '{1, 16'h0007, 8'h00, 8'h4C, 0,  0,   0,  2,  4,  8'h4C, 1, 0};
    vecs[1] = '{0, 16'h0003, 8'hAE, 8'h00, 0,  0,   1,  2,  4,  8'h4C, 0, 0};
    vecs[2] = '{1, 16'h1234, 8'h00, 8'hA5, 3,  1,   0,  5,  7,  8'hA5, 1, 0};
    vecs[3] = '{1, 16'h00FF, 8'h00, 8'h33, 99, 0,   0,  17, 19, 8'hA5, 0, 1};
    vecs[4] = '{0, 16'h8001, 8'h5A, 8'h00, 1,  0,   1,  3,  5,  8'hA5, 0, 0};
    vecs[5] = '{1, 16'hFFFF, 8'h00, 8'h00, 15, 0,   0,  17, 19, 8'h00, 1, 0};

    rst = 1'b0; t3 = 1'b0; ir = '0; aluout = '0; wdata = '0; rd_val = '0;
    probe = 1'b0; mbus.nWAIT = 1'b1;
    #12;
    chk("reset strobes", {29'h0, mbus.nMREQ, mbus.nDRD, mbus.nDWR}, 32'h7);
    chk("reset addr_mdr", {8'h0, mbus.addr, mdr}, 32'h0);
    chk("reset flags", {28'h0, wbin, busy, done, err}, 32'h0);
    check_hiz("reset data_hiz");
    @(negedge clk); rst = 1'b1;

    // Non-memory opcode: nothing may happen on the bus.
    @(negedge clk); t3 = 1'b1; ir = 16'h00B5; aluout = 16'h0055;
    @(negedge clk); t3 = 1'b0; ir = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mbus.nMREQ || busy || done || mbus.addr != 16'h0) bad++;
      @(negedge clk);
    end
    chk("jmp no_activity", bad, 0);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], i, vecs[i].b2b, !(i < 5 && vecs[i+1].b2b));

    // Reset asserted mid-strobe of a store.
    @(negedge clk); t3 = 1'b1; ir = 16'h6000; aluout = 16'h0042; wdata = 8'h3C;
    @(negedge clk); t3 = 1'b0; ir = '0;
    seen_stb = 0;
    for (int i = 0; i < 10 && !seen_stb; i++) begin
      if (!mbus.nDWR) seen_stb = 1;
      else @(negedge clk);
    end
    chk("rst_mid strobe_seen", seen_stb, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid strobes", {29'h0, mbus.nMREQ, mbus.nDRD, mbus.nDWR}, 32'h7);
    chk("rst_mid addr_mdr", {8'h0, mbus.addr, mdr}, 32'h0);
    chk("rst_mid flags", {28'h0, wbin, busy, done, err}, 32'h0);
    check_hiz("rst_mid data_hiz");
    @(negedge clk); @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || wbin || busy || !mbus.nDWR) bad++;
    end
    chk("rst_mid no_resume", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
